// File: rtl/fwb_master.sv
// fwb_master: passive Wishbone master-side protocol monitor.
//
// Watches a Wishbone bus (never drives it), counts accepted requests and
// acknowledgements, and records protocol-rule violations as sticky flags.
//
// Ports
//   i_clk, i_reset         clock, synchronous active-high reset
//   i_wb_cyc/stb/we        observed master controls
//   i_wb_addr/data/sel     observed request fields
//   i_wb_ack/stall/err     observed slave responses
//   i_wb_idata             slave read data (not checked)
//   f_nreqs, f_nacks       accepted-request / response counters for this cycle
//   f_outstanding          f_nreqs - f_nacks while cyc is high, else 0
//   o_f_violation          sticky per-rule violation flags, cleared by reset
//
// Violation bits
//   0  stb while cyc low
//   1  stalled request changed or withdrawn
//   2  we changed during cyc
//   3  ack/err with nothing outstanding, or while cyc low
//   4  ack and err together
//   5  stall longer than F_MAX_STALL (F_MAX_STALL > 0 only)
//   6  ack delay longer than F_MAX_ACK_DELAY (F_MAX_ACK_DELAY > 0 only)
//   7  cyc still high in the cycle after err
//   8  stb re-rose within one cyc (F_OPT_DISCONTINUOUS = 0 only)
//   9  request counter saturated
//   10 bus activity in the cycle right after reset
//
// Build option: define FWB_ASSERT_EN to also raise an immediate assertion
// for each rule at detection (bits 3, 4 and 6 become assumptions under FORMAL).

module fwb_master #(
  parameter int          AW                   = 32,
  parameter int          DW                   = 32,
  parameter int          F_LGDEPTH            = 4,
  parameter int unsigned F_MAX_STALL          = 0,
  parameter int unsigned F_MAX_ACK_DELAY      = 0,
  parameter bit          F_OPT_RMW_BUS_OPTION = 1'b1,
  parameter bit          F_OPT_DISCONTINUOUS  = 1'b0
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_wb_cyc,
  input  logic                 i_wb_stb,
  input  logic                 i_wb_we,
  input  logic [AW-1:0]        i_wb_addr,
  input  logic [DW-1:0]        i_wb_data,
  input  logic [DW/8-1:0]      i_wb_sel,
  input  logic                 i_wb_ack,
  input  logic                 i_wb_stall,
  input  logic                 i_wb_err,
  input  logic [DW-1:0]        i_wb_idata,
  output logic [F_LGDEPTH-1:0] f_nreqs,
  output logic [F_LGDEPTH-1:0] f_nacks,
  output logic [F_LGDEPTH-1:0] f_outstanding,
  output logic [10:0]          o_f_violation
);

  localparam logic [31:0] MAX_STALL     = F_MAX_STALL;
  localparam logic [31:0] MAX_ACK_DELAY = F_MAX_ACK_DELAY;

  logic [F_LGDEPTH-1:0] nreqs_q, nreqs_d;
  logic [F_LGDEPTH-1:0] nacks_q, nacks_d;
  logic [31:0]          stall_cnt_q, stall_cnt_d;
  logic [31:0]          ackdly_cnt_q, ackdly_cnt_d;
  logic                 stalled_q, cyc_q, err_q, reset_q;
  logic                 stb_seen_q, stb_seen_d;
  logic                 stb_fell_q, stb_fell_d;
  logic                 we_q;
  logic [AW-1:0]        addr_q;
  logic [DW-1:0]        data_q;
  logic [DW/8-1:0]      sel_q;
  logic [10:0]          viol_q, viol_d;

  logic accept, stalled, ack_any, waiting;

  // Read data is outside the scope of this monitor.
  logic unused_idata;
  assign unused_idata = ^i_wb_idata;

  assign accept  = i_wb_cyc & i_wb_stb & ~i_wb_stall;
  assign stalled = i_wb_cyc & i_wb_stb & i_wb_stall;
  assign ack_any = i_wb_ack | i_wb_err;

  assign f_nreqs       = nreqs_q;
  assign f_nacks       = nacks_q;
  assign f_outstanding = i_wb_cyc ? (nreqs_q - nacks_q) : '0;

  assign waiting = (f_outstanding != '0) & ~ack_any;

  // Dropping cyc aborts the cycle: counters start over on the next one.
  always_comb begin
    nreqs_d = nreqs_q;
    nacks_d = nacks_q;
    if (!i_wb_cyc) begin
      nreqs_d = '0;
      nacks_d = '0;
    end else begin
      // Saturate rather than wrap so f_outstanding stays meaningful.
      if (accept && (nreqs_q != '1))
        nreqs_d = nreqs_q + F_LGDEPTH'(1);
      if (ack_any)
        nacks_d = nacks_q + F_LGDEPTH'(1);
    end
  end

  // Timers stop counting once past their limit so they cannot wrap.
  always_comb begin
    stall_cnt_d = '0;
    if (stalled)
      stall_cnt_d = (stall_cnt_q > MAX_STALL) ? stall_cnt_q : stall_cnt_q + 32'd1;
    ackdly_cnt_d = '0;
    if (waiting)
      ackdly_cnt_d = (ackdly_cnt_q > MAX_ACK_DELAY) ? ackdly_cnt_q : ackdly_cnt_q + 32'd1;
  end

  // stb_fell marks that stb has gone high and then low inside the current cyc.
  assign stb_seen_d = i_wb_cyc & (stb_seen_q | i_wb_stb);
  assign stb_fell_d = i_wb_cyc & (stb_fell_q | (stb_seen_q & ~i_wb_stb));

  always_comb begin
    viol_d     = '0;
    viol_d[0]  = i_wb_stb & ~i_wb_cyc;
    viol_d[1]  = stalled_q & i_wb_cyc &
                 (~i_wb_stb | (i_wb_we != we_q) | (i_wb_addr != addr_q) |
                  (i_wb_sel != sel_q) | (i_wb_we & (i_wb_data != data_q)));
    // A read-modify-write may flip we once the bus has gone quiet.
    viol_d[2]  = cyc_q & i_wb_cyc & (i_wb_we != we_q) &
                 ~(F_OPT_RMW_BUS_OPTION & (f_outstanding == '0));
    viol_d[3]  = ack_any & (~i_wb_cyc | (f_outstanding == '0));
    viol_d[4]  = i_wb_ack & i_wb_err;
    viol_d[5]  = (F_MAX_STALL != 0) && (stall_cnt_d > MAX_STALL);
    viol_d[6]  = (F_MAX_ACK_DELAY != 0) && (ackdly_cnt_d > MAX_ACK_DELAY);
    viol_d[7]  = err_q & i_wb_cyc;
    viol_d[8]  = ~F_OPT_DISCONTINUOUS & i_wb_cyc & i_wb_stb & stb_fell_q;
    viol_d[9]  = accept & (nreqs_q == '1);
    viol_d[10] = reset_q & (i_wb_cyc | i_wb_stb | i_wb_ack | i_wb_err);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      nreqs_q      <= '0;
      nacks_q      <= '0;
      stall_cnt_q  <= '0;
      ackdly_cnt_q <= '0;
      stalled_q    <= 1'b0;
      cyc_q        <= 1'b0;
      err_q        <= 1'b0;
      reset_q      <= 1'b1;
      stb_seen_q   <= 1'b0;
      stb_fell_q   <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      sel_q        <= '0;
      viol_q       <= '0;
    end else begin
      nreqs_q      <= nreqs_d;
      nacks_q      <= nacks_d;
      stall_cnt_q  <= stall_cnt_d;
      ackdly_cnt_q <= ackdly_cnt_d;
      stalled_q    <= stalled;
      cyc_q        <= i_wb_cyc;
      err_q        <= i_wb_cyc & i_wb_err;
      reset_q      <= 1'b0;
      stb_seen_q   <= stb_seen_d;
      stb_fell_q   <= stb_fell_d;
      we_q         <= i_wb_we;
      addr_q       <= i_wb_addr;
      data_q       <= i_wb_data;
      sel_q        <= i_wb_sel;
      viol_q       <= viol_q | viol_d;
    end
  end

  assign o_f_violation = viol_q;

`ifdef FWB_ASSERT_EN
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      for (int b = 0; b < 11; b++) begin
`ifdef FORMAL
        // Slave-side rules constrain the environment rather than the master.
        if (b == 3 || b == 4 || b == 6)
          assume (!viol_d[b]);
        else
          assert (!viol_d[b]);
`else
        assert (!viol_d[b]);
`endif
      end
    end
  end
`else
  // Flags are reported through o_f_violation only.
`endif

endmodule

// File: tb/tb_fwb_master.sv
// Directed bench for fwb_master (F_MAX_STALL=2, F_MAX_ACK_DELAY=3, 4-bit counters).
// Inputs change 1 time unit after the rising edge; outputs are checked between edges.

module tb_fwb_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we, ack, stall, err;
  logic [31:0] addr, data, idata;
  logic [3:0]  sel;
  logic [3:0]  nreqs, nacks, outst;
  logic [10:0] viol;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fwb_master #(
    .AW(32), .DW(32), .F_LGDEPTH(4),
    .F_MAX_STALL(2), .F_MAX_ACK_DELAY(3),
    .F_OPT_RMW_BUS_OPTION(1'b1), .F_OPT_DISCONTINUOUS(1'b0)
  ) dut (
    .i_clk(clk), .i_reset(rst),
    .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_addr(addr), .i_wb_data(data), .i_wb_sel(sel),
    .i_wb_ack(ack), .i_wb_stall(stall), .i_wb_err(err),
    .i_wb_idata(idata),
    .f_nreqs(nreqs), .f_nacks(nacks), .f_outstanding(outst),
    .o_f_violation(viol)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic c, input logic s, input logic w,
                     input logic st, input logic a, input logic e);
    cyc = c; stb = s; we = w; stall = st; ack = a; err = e;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus(0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; addr = '0; data = '0; sel = 4'hF; idata = '0;
    bus(0, 0, 0, 0, 0, 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_nreqs", 32'(nreqs), 32'd0);
    chk("rst_nacks", 32'(nacks), 32'd0);
    chk("rst_outst", 32'(outst), 32'd0);
    chk("rst_viol",  32'(viol),  32'd0);

    // Single read
    addr = 32'h10;
    bus(1, 1, 0, 0, 0, 0);
    chk("rd_outst0", 32'(outst), 32'd0);
    tick();
    bus(1, 0, 0, 0, 1, 0);
    chk("rd_nreqs", 32'(nreqs), 32'd1);
    chk("rd_nacks0", 32'(nacks), 32'd0);
    chk("rd_outst1", 32'(outst), 32'd1);
    tick();
    bus(1, 0, 0, 0, 0, 0);
    chk("rd_nacks1", 32'(nacks), 32'd1);
    chk("rd_outst_done", 32'(outst), 32'd0);
    tick();
    bus(0, 0, 0, 0, 0, 0);
    tick();
    chk("rd_nreqs_clr", 32'(nreqs), 32'd0);
    chk("rd_viol", 32'(viol), 32'd0);

    // Address changed under stall -> bit1, sticky
    addr = 32'h10;
    bus(1, 1, 0, 1, 0, 0);
    tick();
    addr = 32'h14;
    bus(1, 1, 0, 1, 0, 0);
    tick();
    chk("stall_addr_chg", 32'(viol), 32'h002);
    bus(0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk("bit1_sticky", 32'(viol), 32'h002);
    do_reset();
    chk("bit1_cleared", 32'(viol), 32'd0);

    // Ack with nothing outstanding -> bit3
    bus(1, 0, 0, 0, 1, 0);
    tick();
    chk("ack0_nacks", 32'(nacks), 32'd1);
    chk("ack0_viol", 32'(viol), 32'h008);
    do_reset();

    // Ack and err together -> bit4
    bus(1, 1, 0, 0, 0, 0);
    tick();
    bus(1, 0, 0, 0, 1, 1);
    tick();
    bus(0, 0, 0, 0, 0, 0);
    tick();
    chk("ack_err", 32'(viol), 32'h010);
    do_reset();

    // Stall held 2 cycles: allowed
    addr = 32'h20;
    bus(1, 1, 0, 1, 0, 0);
    tick(); tick();
    bus(1, 1, 0, 0, 0, 0);
    tick();
    bus(1, 0, 0, 0, 1, 0);
    tick();
    bus(0, 0, 0, 0, 0, 0);
    tick();
    chk("stall2_ok", 32'(viol), 32'd0);

    // Stall held 3 cycles -> bit5
    bus(1, 1, 0, 1, 0, 0);
    tick(); tick(); tick();
    bus(0, 0, 0, 0, 0, 0);
    tick();
    chk("stall3", 32'(viol), 32'h020);
    do_reset();

    // Err then cyc dropped: clean abort
    bus(1, 1, 0, 0, 0, 0);
    tick();
    bus(1, 0, 0, 0, 0, 1);
    tick();
    chk("err_nacks", 32'(nacks), 32'd1);
    bus(0, 0, 0, 0, 0, 0);
    tick();
    chk("err_drop_nreqs", 32'(nreqs), 32'd0);
    chk("err_drop_nacks", 32'(nacks), 32'd0);
    chk("err_drop_viol", 32'(viol), 32'd0);

    // Err then cyc held -> bit7
    bus(1, 1, 0, 0, 0, 0);
    tick();
    bus(1, 0, 0, 0, 0, 1);
    tick();
    bus(1, 0, 0, 0, 0, 0);
    tick();
    bus(0, 0, 0, 0, 0, 0);
    tick();
    chk("err_cyc_held", 32'(viol), 32'h080);
    do_reset();

    // we changed with a request outstanding -> bit2
    bus(1, 1, 0, 0, 0, 0);
    tick();
    bus(1, 0, 1, 0, 0, 0);
    tick();
    bus(0, 0, 0, 0, 0, 0);
    tick();
    chk("we_chg", 32'(viol), 32'h004);
    do_reset();

    // we changed while idle inside cyc: read-modify-write allowance
    bus(1, 0, 0, 0, 0, 0);
    tick();
    bus(1, 1, 1, 0, 0, 0);
    tick();
    bus(1, 0, 1, 0, 1, 0);
    tick();
    bus(0, 0, 0, 0, 0, 0);
    tick();
    chk("rmw_ok", 32'(viol), 32'd0);

    // stb re-rises within one cyc -> bit8
    bus(1, 1, 0, 0, 0, 0);
    tick();
    bus(1, 0, 0, 0, 1, 0);
    tick();
    bus(1, 1, 0, 0, 0, 0);
    tick();
    bus(0, 0, 0, 0, 0, 0);
    tick();
    chk("stb_rerise", 32'(viol), 32'h100);
    do_reset();

    // Ack after 3 waiting cycles: allowed; after 4 -> bit6
    bus(1, 1, 0, 0, 0, 0);
    tick();
    bus(1, 0, 0, 0, 0, 0);
    tick(); tick(); tick();
    bus(1, 0, 0, 0, 1, 0);
    tick();
    bus(0, 0, 0, 0, 0, 0);
    tick();
    chk("ackdly3_ok", 32'(viol), 32'd0);
    bus(1, 1, 0, 0, 0, 0);
    tick();
    bus(1, 0, 0, 0, 0, 0);
    tick(); tick(); tick(); tick();
    bus(0, 0, 0, 0, 0, 0);
    tick();
    chk("ackdly4", 32'(viol), 32'h040);
    do_reset();

    // stb while cyc low -> bit0
    bus(0, 1, 0, 0, 0, 0);
    tick();
    bus(0, 0, 0, 0, 0, 0);
    tick();
    chk("stb_no_cyc", 32'(viol), 32'h001);
    do_reset();

    // Bus active right after reset -> bit10
    rst = 1'b1;
    bus(0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    bus(1, 1, 0, 0, 0, 0);
    tick();
    bus(0, 0, 0, 0, 0, 0);
    tick();
    chk("post_reset_act", 32'(viol), 32'h400);
    do_reset();

    // 16 back-to-back requests: counter saturates at 15 -> bit9
    bus(1, 1, 0, 0, 0, 0);
    tick();
    bus(1, 1, 0, 0, 1, 0);
    for (int i = 0; i < 15; i++) tick();
    chk("sat_nreqs", 32'(nreqs), 32'd15);
    chk("sat_nacks", 32'(nacks), 32'd15);
    chk("sat_viol", 32'(viol), 32'h200);
    bus(0, 0, 0, 0, 0, 0);
    tick();
    do_reset();

    // Reset with 3 requests outstanding
    for (int i = 0; i < 3; i++) begin
      addr = 32'(i * 4);
      bus(1, 1, 0, 0, 0, 0);
      tick();
    end
    bus(1, 0, 0, 0, 0, 0);
    chk("pre_rst_nreqs", 32'(nreqs), 32'd3);
    chk("pre_rst_outst", 32'(outst), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus(0, 0, 0, 0, 0, 0);
    chk("mid_rst_nreqs", 32'(nreqs), 32'd0);
    chk("mid_rst_nacks", 32'(nacks), 32'd0);
    chk("mid_rst_outst", 32'(outst), 32'd0);
    chk("mid_rst_viol", 32'(viol), 32'd0);
    tick();
    chk("mid_rst_quiet", 32'(viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwb_master.md
FWB_MASTER -- requirements
Module: fwb_master

Interface
REQ-001 Parameter AW, 32, address width in words.
REQ-002 Parameter DW, 32, data width; DW/8 select bits.
REQ-003 Parameter F_LGDEPTH, 4, width of request/ack counters.
REQ-004 Parameter F_MAX_STALL, 0, max consecutive stalled-request cycles; 0 disables the check.
REQ-005 Parameter F_MAX_ACK_DELAY, 0, max cycles an outstanding request waits for ack/err; 0 disables the check.
REQ-006 Parameter F_OPT_RMW_BUS_OPTION, 1; 1 lets i_wb_we change within a cycle when f_outstanding==0; 0 forbids any change while i_wb_cyc is high.
REQ-007 Parameter F_OPT_DISCONTINUOUS, 0; 1 allows stb to re-rise within one cyc; 0 forbids it.
REQ-008 Port i_clk, in, 1, clock; reset i_reset, synchronous, active-high; clock i_clk.
REQ-009 Port i_reset, in, 1, synchronous active-high reset.
REQ-010 Ports i_wb_cyc, i_wb_stb, i_wb_we, in, 1 each, observed master controls.
REQ-011 Ports i_wb_addr (AW), i_wb_data (DW), i_wb_sel (DW/8), in, observed request fields.
REQ-012 Ports i_wb_ack, i_wb_stall, i_wb_err, in, 1 each; i_wb_idata, in, DW, slave read data (unchecked).
REQ-013 Ports f_nreqs, f_nacks, f_outstanding, out, F_LGDEPTH each, transaction counters.
REQ-014 Port o_f_violation, out, 11, sticky per-rule violation flags (last port, may be left unconnected).

Function
REQ-015 Monitor is passive; it never drives bus signals.
REQ-016 Request accepted when cyc && stb && !stall; f_nreqs increments on each accepted request.
REQ-017 f_nacks increments on each cycle with cyc && (ack || err).
REQ-018 When cyc is low, f_nreqs and f_nacks clear to 0 at the next edge.
REQ-019 f_outstanding = cyc ? f_nreqs - f_nacks : 0, combinational, modulo 2^F_LGDEPTH.
REQ-020 Violations are detected combinationally from current inputs and one-cycle-registered history; the flag bit is set at the next clock edge and holds until reset.
REQ-021 Bit0: stb high while cyc low.
REQ-022 Bit1: previous cycle had cyc && stb && stall, current cycle has cyc but stb dropped or we/addr/sel changed, or data changed with we=1.
REQ-023 Bit2: we changed while cyc high, excepting the F_OPT_RMW_BUS_OPTION=1 case of f_outstanding==0.
REQ-024 Bit3: ack or err while f_outstanding==0 (zero-latency ack is illegal), or either while cyc low.
REQ-025 Bit4: ack and err both high in one cycle.
REQ-026 Bit5: stall counter (consecutive cyc && stb && stall cycles) exceeds F_MAX_STALL, F_MAX_STALL>0 only.
REQ-027 Bit6: ack-delay counter (consecutive cycles with f_outstanding>0 and no ack/err) exceeds F_MAX_ACK_DELAY, F_MAX_ACK_DELAY>0 only.
REQ-028 Bit7: cyc still high in the cycle after err.
REQ-029 Bit8: F_OPT_DISCONTINUOUS=0 and stb rises after having fallen within the same cyc.
REQ-030 Bit9: f_nreqs would wrap past 2^F_LGDEPTH-1; counter saturates.
REQ-031 Bit10: cyc, stb, ack or err high in the cycle after a reset cycle.
REQ-032 Dropping cyc aborts the cycle: all timers clear, outstanding requests are discarded without violation.

Reset
REQ-033 While i_reset is high, counters, timers, history registers and o_f_violation clear to 0 at the edge; reset mid-transaction discards it.
REQ-034 Counters outputs read 0 in the cycle following reset.

Configuration
REQ-035 With FWB_ASSERT_EN defined, each rule additionally fires a simulation/formal assertion (slave-side rules 3,4,6 as assumptions under formal) at detection; without it, only o_f_violation reports, fully synthesizable.

Verification
REQ-036 Single read: cyc+stb 1 cycle, no stall, ack next cycle -> f_nreqs=1, f_nacks=1, f_outstanding 1 then 0, o_f_violation=0.
REQ-037 Stalled request with addr changed 0x10->0x14 while stall=1 -> bit1 set next cycle, stays set until reset.
REQ-038 ack with no request outstanding -> bit3 set; ack+err same cycle -> bit4 set.
REQ-039 F_MAX_STALL=2, stall held 3 cycles -> bit5 set; held 2 cycles -> no flag.
REQ-040 err ack then cyc kept high one more cycle -> bit7 set; cyc dropped instead -> counters 0, no flag.
REQ-041 Reset asserted with 3 requests outstanding -> all counters 0 and o_f_violation=0 next cycle.
